// File: rtl/tile_mem_sequencer_if.sv
// Decoder command, unified-memory bus and systolic-array delivery signals of the tile memory sequencer.
// The master modport is the sequencer; the slave modport is the decoder/memory/array side.
interface tile_mem_sequencer_if #(
    parameter int N      = 2,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16
) ();
    logic                      load_weight;
    logic                      load_input;
    logic                      store;
    logic [12:0]               base_address;
    logic [N*N*ACC_W-1:0]      acc_in;
    logic [DATA_W-1:0]         mem_rdata;
    logic [12:0]               mem_addr;
    logic                      mem_rd_en;
    logic                      mem_wr_en;
    logic [ACC_W-1:0]          mem_wdata;
    logic [N*N*DATA_W-1:0]     weight_tile;
    logic                      weight_valid;
    logic [N*DATA_W-1:0]       input_row;
    logic                      input_valid;
    logic                      busy;
    logic                      cmd_err;

    modport master (
        input  load_weight, load_input, store, base_address, acc_in, mem_rdata,
        output mem_addr, mem_rd_en, mem_wr_en, mem_wdata,
               weight_tile, weight_valid, input_row, input_valid, busy, cmd_err
    );

    modport slave (
        output load_weight, load_input, store, base_address, acc_in, mem_rdata,
        input  mem_addr, mem_rd_en, mem_wr_en, mem_wdata,
               weight_tile, weight_valid, input_row, input_valid, busy, cmd_err
    );
endinterface

// File: rtl/tile_mem_sequencer.sv
// Turns decoder load/store strobes into unified-memory bus cycles, delivers weight tiles and
// input rows to the systolic array, and writes accumulator tiles back. All outputs are registered.
module tile_mem_sequencer #(
    parameter int N      = 2,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    tile_mem_sequencer_if.master bus
);
    localparam int TILE  = N * N;
    localparam int CNT_W = $clog2(TILE + 1);
    localparam int AW    = 13;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_READ    = 3'd1,
        S_DRAIN   = 3'd2,
        S_DELIVER = 3'd3,
        S_WRITE   = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        OP_WEIGHT = 2'd0,
        OP_INPUT  = 2'd1,
        OP_STORE  = 2'd2
    } op_e;

    state_e                 state_q, state_d;
    op_e                    op_q, op_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [AW-1:0]          base_q, base_d;
    logic [TILE*ACC_W-1:0]  acc_q, acc_d;
    logic [TILE*DATA_W-1:0] buf_q, buf_d;
    logic [2:0]             strobe_prev_q;

    logic [2:0]             strobe_s;
    logic [2:0]             edge_s;
    logic                   multi_edge_s;
    logic                   err_set_s;

    logic [AW-1:0]          mem_addr_q, mem_addr_d;
    logic                   mem_rd_en_q, mem_rd_en_d;
    logic                   mem_wr_en_q, mem_wr_en_d;
    logic [ACC_W-1:0]       mem_wdata_q, mem_wdata_d;
    logic [TILE*DATA_W-1:0] weight_tile_q, weight_tile_d;
    logic                   weight_valid_q, weight_valid_d;
    logic [N*DATA_W-1:0]    input_row_q, input_row_d;
    logic                   input_valid_q, input_valid_d;
    logic                   busy_q, busy_d;
    logic                   cmd_err_q, cmd_err_d;

    // Strobe bit order {load_weight, load_input, store}; a command is a rising edge.
    assign strobe_s     = {bus.load_weight, bus.load_input, bus.store};
    assign edge_s       = strobe_s & ~strobe_prev_q;
    assign multi_edge_s = ((edge_s & (edge_s - 3'd1)) != 3'd0);
    assign err_set_s    = (state_q == S_IDLE) ? multi_edge_s : (edge_s != 3'd0);

    // Next-state, operand latching and read-data capture.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        base_d  = base_q;
        acc_d   = acc_q;
        buf_d   = buf_q;
        case (state_q)
            S_IDLE: begin
                if (edge_s != 3'd0) begin
                    base_d = bus.base_address;
                    cnt_d  = '0;
                    if (edge_s[2]) begin
                        op_d    = OP_WEIGHT;
                        state_d = S_READ;
                    end else if (edge_s[1]) begin
                        op_d    = OP_INPUT;
                        state_d = S_READ;
                    end else begin
                        op_d    = OP_STORE;
                        acc_d   = bus.acc_in;
                        state_d = S_WRITE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_READ: begin
                // Read data lags its request by one cycle, so slot cnt-1 lands now.
                if (cnt_q != '0) begin
                    buf_d[(int'(cnt_q) - 1) * DATA_W +: DATA_W] = bus.mem_rdata;
                end else begin
                    buf_d = buf_q;
                end
                if (cnt_q == CNT_W'(TILE - 1)) begin
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            S_DRAIN: begin
                buf_d[(TILE - 1) * DATA_W +: DATA_W] = bus.mem_rdata;
                cnt_d   = '0;
                state_d = S_DELIVER;
            end
            S_DELIVER: begin
                if ((op_q == OP_INPUT) && (cnt_q != CNT_W'(N - 1))) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            S_WRITE: begin
                if (cnt_q == CNT_W'(TILE - 1)) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Output values for the coming cycle, derived from the next state so they register in step with it.
    always_comb begin
        mem_rd_en_d    = (state_d == S_READ);
        mem_wr_en_d    = (state_d == S_WRITE);
        weight_valid_d = (state_d == S_DELIVER) && (op_d == OP_WEIGHT);
        input_valid_d  = (state_d == S_DELIVER) && (op_d == OP_INPUT);
        busy_d         = (state_d != S_IDLE);
        cmd_err_d      = cmd_err_q | err_set_s;
        if (mem_rd_en_d || mem_wr_en_d) begin
            mem_addr_d = base_d + AW'(cnt_d);
        end else begin
            mem_addr_d = '0;
        end
        if (mem_wr_en_d) begin
            mem_wdata_d = acc_d[int'(cnt_d) * ACC_W +: ACC_W];
        end else begin
            mem_wdata_d = '0;
        end
        // The weight tile is only replaced when a new one is complete.
        if (weight_valid_d) begin
            weight_tile_d = buf_d;
        end else begin
            weight_tile_d = weight_tile_q;
        end
        if (input_valid_d) begin
            input_row_d = buf_d[int'(cnt_d) * N * DATA_W +: N * DATA_W];
        end else begin
            input_row_d = input_row_q;
        end
    end

    // State, operand and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            op_q           <= OP_WEIGHT;
            cnt_q          <= '0;
            base_q         <= '0;
            acc_q          <= '0;
            buf_q          <= '0;
            strobe_prev_q  <= 3'd0;
            mem_addr_q     <= '0;
            mem_rd_en_q    <= 1'b0;
            mem_wr_en_q    <= 1'b0;
            mem_wdata_q    <= '0;
            weight_tile_q  <= '0;
            weight_valid_q <= 1'b0;
            input_row_q    <= '0;
            input_valid_q  <= 1'b0;
            busy_q         <= 1'b0;
            cmd_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            cnt_q          <= cnt_d;
            base_q         <= base_d;
            acc_q          <= acc_d;
            buf_q          <= buf_d;
            strobe_prev_q  <= strobe_s;
            mem_addr_q     <= mem_addr_d;
            mem_rd_en_q    <= mem_rd_en_d;
            mem_wr_en_q    <= mem_wr_en_d;
            mem_wdata_q    <= mem_wdata_d;
            weight_tile_q  <= weight_tile_d;
            weight_valid_q <= weight_valid_d;
            input_row_q    <= input_row_d;
            input_valid_q  <= input_valid_d;
            busy_q         <= busy_d;
            cmd_err_q      <= cmd_err_d;
        end
    end

    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_rd_en    = mem_rd_en_q;
    assign bus.mem_wr_en    = mem_wr_en_q;
    assign bus.mem_wdata    = mem_wdata_q;
    assign bus.weight_tile  = weight_tile_q;
    assign bus.weight_valid = weight_valid_q;
    assign bus.input_row    = input_row_q;
    assign bus.input_valid  = input_valid_q;
    assign bus.busy         = busy_q;
    assign bus.cmd_err      = cmd_err_q;
endmodule

// File: tb/tb_tile_mem_sequencer.sv
// Scoreboard bench for tile_mem_sequencer: commands push expected bus/delivery traffic into queues,
// a negedge monitor pops and compares them; a per-command cycle table checks the latencies.
module tb_tile_mem_sequencer;
    localparam int N      = 2;
    localparam int DATA_W = 8;
    localparam int ACC_W  = 16;
    localparam int TILE   = N * N;

    logic clk = 1'b0;
    logic reset_n;

    tile_mem_sequencer_if #(.N(N), .DATA_W(DATA_W), .ACC_W(ACC_W)) bus_if ();

    tile_mem_sequencer #(.N(N), .DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [DATA_W-1:0]      mem [0:8191];
    logic [12:0]            exp_rd_q [$];
    logic [12+ACC_W:0]      exp_wr_q [$];
    logic [TILE*DATA_W-1:0] exp_wt_q [$];
    logic [N*DATA_W-1:0]    exp_row_q [$];
    logic [TILE*DATA_W-1:0] last_weight;
    bit                     err_exp;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory returns the requested byte one cycle after the request.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) bus_if.mem_rdata <= '0;
        else if (bus_if.mem_rd_en) bus_if.mem_rdata <= mem[bus_if.mem_addr];
        else bus_if.mem_rdata <= '0;
    end

    // Monitor: pops the scoreboard whenever the DUT presents a bus cycle or a delivery.
    always @(negedge clk) begin
        if (reset_n) begin
            check("rd_wr_exclusive", 64'(bus_if.mem_rd_en & bus_if.mem_wr_en), 64'd0);
            if (!bus_if.mem_rd_en && !bus_if.mem_wr_en)
                check("idle_addr", 64'(bus_if.mem_addr), 64'd0);
            if (bus_if.mem_rd_en) begin
                if (exp_rd_q.size() == 0) check("unexpected_read", 64'(bus_if.mem_addr), 64'hFFFF);
                else check("read_addr", 64'(bus_if.mem_addr), 64'(exp_rd_q.pop_front()));
            end
            if (bus_if.mem_wr_en) begin
                if (exp_wr_q.size() == 0) check("unexpected_write", 64'(bus_if.mem_addr), 64'hFFFF);
                else check("write_addr_data", 64'({bus_if.mem_addr, bus_if.mem_wdata}),
                           64'(exp_wr_q.pop_front()));
            end
            if (bus_if.weight_valid) begin
                if (exp_wt_q.size() == 0) check("unexpected_weight", 64'(bus_if.weight_tile), 64'hFFFF);
                else check("weight_tile", 64'(bus_if.weight_tile), 64'(exp_wt_q.pop_front()));
            end
            if (bus_if.input_valid) begin
                if (exp_row_q.size() == 0) check("unexpected_row", 64'(bus_if.input_row), 64'hFFFF);
                else check("input_row", 64'(bus_if.input_row), 64'(exp_row_q.pop_front()));
            end
        end
    end

    task automatic clear_model();
        exp_rd_q.delete();
        exp_wr_q.delete();
        exp_wt_q.delete();
        exp_row_q.delete();
        err_exp     = 1'b0;
        last_weight = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_addr"}, 64'(bus_if.mem_addr), 64'd0);
        check({tag, "_rd_wr"}, 64'({bus_if.mem_rd_en, bus_if.mem_wr_en}), 64'd0);
        check({tag, "_wdata"}, 64'(bus_if.mem_wdata), 64'd0);
        check({tag, "_weight_tile"}, 64'(bus_if.weight_tile), 64'd0);
        check({tag, "_input_row"}, 64'(bus_if.input_row), 64'd0);
        check({tag, "_valids"}, 64'({bus_if.weight_valid, bus_if.input_valid}), 64'd0);
        check({tag, "_busy_err"}, 64'({bus_if.busy, bus_if.cmd_err}), 64'd0);
    endtask

    task automatic idle_quiet(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            check("quiet_busy_bus", 64'({bus_if.busy, bus_if.mem_rd_en, bus_if.mem_wr_en}), 64'd0);
        end
    endtask

    // kind: 0 weight load, 1 input load, 2 store. dual_store raises store with the command;
    // late_store raises store in cycle 2 of the command.
    task automatic run_cmd(input int kind, input logic [12:0] base, input int hold,
                           input logic [TILE*ACC_W-1:0] acc, input bit dual_store, input bit late_store);
        logic [TILE*DATA_W-1:0] tile;
        logic [12:0]            a;
        bit                     e_busy, e_rd, e_wr, e_wv, e_iv;
        for (int e = 0; e < TILE; e++) begin
            a = base + 13'(e);
            tile[e*DATA_W +: DATA_W] = mem[a];
            if (kind == 2) exp_wr_q.push_back({a, acc[e*ACC_W +: ACC_W]});
            else exp_rd_q.push_back(a);
        end
        if (kind == 0) begin
            exp_wt_q.push_back(tile);
            last_weight = tile;
        end else if (kind == 1) begin
            for (int r = 0; r < N; r++) exp_row_q.push_back(tile[r*N*DATA_W +: N*DATA_W]);
        end
        if (dual_store || late_store) err_exp = 1'b1;

        @(negedge clk);
        bus_if.base_address = base;
        bus_if.acc_in       = acc;
        case (kind)
            0:       bus_if.load_weight = 1'b1;
            1:       bus_if.load_input  = 1'b1;
            default: bus_if.store       = 1'b1;
        endcase
        if (dual_store) bus_if.store = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (c == 1) begin
                bus_if.base_address = ~base;
                bus_if.acc_in       = ~acc;
            end
            if (c == hold) begin
                bus_if.load_weight = 1'b0;
                bus_if.load_input  = 1'b0;
                bus_if.store       = 1'b0;
            end
            if (late_store && c == 2) bus_if.store = 1'b1;
            if (late_store && c == 3) bus_if.store = 1'b0;
            e_busy = (kind == 0) ? (c <= 6) : (kind == 1) ? (c <= 7) : (c <= 4);
            e_rd   = (kind != 2) && (c <= 4);
            e_wr   = (kind == 2) && (c <= 4);
            e_wv   = (kind == 0) && (c == 6);
            e_iv   = (kind == 1) && (c == 6 || c == 7);
            check("busy_timing", 64'(bus_if.busy), 64'(e_busy));
            check("rd_en_timing", 64'(bus_if.mem_rd_en), 64'(e_rd));
            check("wr_en_timing", 64'(bus_if.mem_wr_en), 64'(e_wr));
            check("weight_valid_timing", 64'(bus_if.weight_valid), 64'(e_wv));
            check("input_valid_timing", 64'(bus_if.input_valid), 64'(e_iv));
        end
        check("weight_tile_held", 64'(bus_if.weight_tile), 64'(last_weight));
        check("cmd_err", 64'(bus_if.cmd_err), 64'(err_exp));
        check("scoreboard_drained",
              64'(exp_rd_q.size() + exp_wr_q.size() + exp_wt_q.size() + exp_row_q.size()), 64'd0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset_n = 1'b0;
        #1 check_all_zero("reset_pulse");
        clear_model();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic reset_mid_read(input logic [12:0] base);
        for (int e = 0; e < TILE; e++) exp_rd_q.push_back(base + 13'(e));
        @(negedge clk);
        bus_if.base_address = base;
        bus_if.load_weight  = 1'b1;
        @(negedge clk);
        bus_if.load_weight = 1'b0;
        repeat (2) @(negedge clk);
        check("read_before_reset", 64'({bus_if.busy, bus_if.mem_rd_en}), 64'd3);
        #2 reset_n = 1'b0;
        #1 check_all_zero("mid_read_reset");
        clear_model();
        @(negedge clk);
        reset_n = 1'b1;
        idle_quiet(4);
    endtask

    initial begin
        logic [12:0] rb;
        int          kind;
        reset_n             = 1'b0;
        bus_if.load_weight  = 1'b0;
        bus_if.load_input   = 1'b0;
        bus_if.store        = 1'b0;
        bus_if.base_address = '0;
        bus_if.acc_in       = '0;
        clear_model();
        for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);
        mem[16] = 8'd11; mem[17] = 8'd22; mem[18] = 8'd33; mem[19] = 8'd44;
        mem[32] = 8'd1;  mem[33] = 8'd2;  mem[34] = 8'd3;  mem[35] = 8'd4;

        repeat (3) @(negedge clk);
        check_all_zero("initial_reset");
        reset_n = 1'b1;
        idle_quiet(2);

        run_cmd(0, 13'h010, 1, 64'(0), 1'b0, 1'b0);
        check("spec_weight_tile", 64'(bus_if.weight_tile), 64'h2C21160B);
        run_cmd(1, 13'h020, 1, 64'(0), 1'b0, 1'b0);
        run_cmd(2, 13'h1FFE, 1, {16'd400, 16'd300, 16'd200, 16'd100}, 1'b0, 1'b0);
        run_cmd(0, 13'h0040, 3, 64'(0), 1'b0, 1'b0);
        run_cmd(1, 13'h0050, 1, 64'(0), 1'b0, 1'b1);
        reset_mid_read(13'h1FFD);
        run_cmd(0, 13'h0100, 2, 64'(0), 1'b1, 1'b0);
        pulse_reset();
        idle_quiet(1);

        for (int n = 0; n < 40; n++) begin
            kind = int'($urandom_range(0, 2));
            if ($urandom_range(0, 3) == 0) rb = 13'h1FFC + 13'($urandom_range(0, 3));
            else rb = 13'($urandom);
            run_cmd(kind, rb, int'($urandom_range(1, 3)), {$urandom, $urandom}, 1'b0,
                    (kind != 2) && ($urandom_range(0, 9) == 0));
        end

        idle_quiet(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
